// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline definitions.
//   rgb12_t         : 4-bit-per-channel colour, packed {r,g,b}
//   PAL_IDX_W       : palette index width
//   TRANSPARENT_IDX : palette index that acts as the transparent colour key
package sprite_pkg;

  localparam int PAL_IDX_W = 8;
  localparam logic [PAL_IDX_W-1:0] TRANSPARENT_IDX = 8'h00;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches req upward from ptr,
// wrapping modulo NUM_REQ, and grants the first requester found.
// The pointer register is owned by the parent.
//   req     : request vector
//   ptr     : highest-priority requester this cycle (must be < NUM_REQ)
//   en      : grant enable; 0 forces no grant
//   gnt     : one-hot grant
//   gnt_id  : encoded index of the granted requester (0 when none)
//   gnt_vld : a grant was issued
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      // Modulo rather than a bit mask so non-power-of-two counts wrap correctly.
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = ID_W'(idx);
      end
    end
  end

  assign gnt_vld = found;

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one external combinational sprite palette among NUM_REQ sprite
// engines. A round-robin arbiter picks one index per cycle; stage A drives
// it onto pal_index, stage B captures the palette colour and returns it
// tagged with the requester id two cycles after the grant.
//   clk, reset_n        : clock, asynchronous active-low reset
//   req, req_index      : per-requester request and packed 8-bit index
//   req_gnt             : combinational one-hot grant
//   stall               : freeze pipeline and pointer, no grants
//   sync_clear          : frame/line start, drop in-flight lookups, pointer=0
//   pal_index           : registered address to the shared palette
//   pal_red/green/blue  : palette colour for pal_index
//   rsp_valid, rsp_id   : response strobe and owning requester
//   rsp_rgb             : {red,green,blue}
//   rsp_transparent     : looked-up index was the transparent key
module palette_lookup_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = PAL_IDX_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_gnt,
  input  logic                     stall,
  input  logic                     sync_clear,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [11:0]              rsp_rgb,
  output logic                     rsp_transparent
);

  localparam int STAGES = 2;

  logic [NUM_REQ-1:0][IDX_W-1:0] idx_arr;
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [ID_W-1:0]               gnt_id;
  logic                          gnt_vld;
  logic                          arb_en;

  // vld_pipe_q[1] = stage A valid, vld_pipe_q[STAGES] = response valid
  logic [STAGES:1]               vld_pipe_q;
  logic [IDX_W-1:0]              pal_index_q;
  logic [ID_W-1:0]               a_id_q;
  logic [ID_W-1:0]               rsp_id_q;
  rgb12_t                        rsp_rgb_q;
  logic                          rsp_tr_q;

  assign idx_arr = req_index;

  // Reset is folded in so no grant is visible while reset is held.
  assign arb_en = reset_n & ~stall & ~sync_clear;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (req_gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld)
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      vld_pipe_q  <= '0;
      pal_index_q <= '0;
      a_id_q      <= '0;
      rsp_id_q    <= '0;
      rsp_rgb_q   <= '0;
      rsp_tr_q    <= 1'b0;
    end else if (sync_clear) begin
      // Discard in-flight lookups; address and response data hold.
      ptr_q      <= '0;
      vld_pipe_q <= '0;
    end else if (!stall) begin
      ptr_q         <= ptr_d;
      vld_pipe_q[1] <= gnt_vld;
      vld_pipe_q[2] <= vld_pipe_q[1];
      if (gnt_vld) begin
        pal_index_q <= idx_arr[gnt_id];
        a_id_q      <= gnt_id;
      end
      if (vld_pipe_q[1]) begin
        rsp_id_q  <= a_id_q;
        rsp_rgb_q <= '{r: pal_red, g: pal_green, b: pal_blue};
        rsp_tr_q  <= (pal_index_q == IDX_W'(TRANSPARENT_IDX));
      end
    end
  end

  assign pal_index       = pal_index_q;
  assign rsp_valid       = vld_pipe_q[STAGES];
  assign rsp_id          = rsp_id_q;
  assign rsp_rgb         = rsp_rgb_q;
  assign rsp_transparent = rsp_tr_q;

endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
Shares one combinational 256-entry, 12-bit sprite palette (turret/tank palettes) among several sprite engines that each need an 8-bit index translated to RGB. Round-robin arbiter plus a 2-stage pipeline: stage A registers the granted index onto the palette address, stage B captures the palette's RGB and returns it tagged with the requester id. Sits between the per-sprite ROM readers and the VGA pixel compositor.

Parameters:
NUM_REQ, 4, number of requesting sprite engines (2..8)
IDX_W, 8, palette index width
ID_W, $clog2(NUM_REQ), requester id width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester lookup request
req_index  in  NUM_REQ*IDX_W  packed indices, requester i at bits [i*IDX_W +: IDX_W]
req_gnt  out  NUM_REQ  one-hot grant, combinational; transfer when req[i]&&req_gnt[i]
stall  in  1  freeze: no grants, all pipeline registers hold
sync_clear  in  1  frame/line start: flush pipeline, reset pointer
pal_index  out  IDX_W  registered address to the shared palette
pal_red, pal_green, pal_blue  in  4 each  combinational palette output for pal_index
rsp_valid  out  1  response valid, one-cycle pulse per transfer
rsp_id  out  ID_W  requester that owns the response
rsp_rgb  out  12  {red,green,blue}
rsp_transparent  out  1  high when the looked-up index was 0 (transparent key)

Behaviour:
- Reset (reset_n low, asynchronous): pal_index=0, stage-A valid=0, a_id=0, rsp_valid=0, rsp_id=0, rsp_rgb=0, rsp_transparent=0, rr pointer=0. req_gnt=0 while reset asserted.
- Arbitration: search req starting at rr pointer, ascending, wrapping mod NUM_REQ; the first set bit gets req_gnt. At most one grant per cycle. req_gnt depends only on req, the pointer, stall and sync_clear. Requesters hold req/req_index stable until granted.
- Pointer: on a grant to i, pointer <= (i+1) mod NUM_REQ (wraps at NUM_REQ-1 -> 0, not a power-of-two mask). No grant -> pointer holds.
- Stage A (grant cycle N): pal_index <= req_index[i], a_valid <= 1, a_id <= i. No grant -> a_valid <= 0, pal_index holds its last value.
- Stage B (cycle N+1): rsp_valid <= a_valid; when a_valid: rsp_id <= a_id, rsp_rgb <= {pal_red,pal_green,pal_blue}, rsp_transparent <= (pal_index==0). rsp_rgb/id hold when a_valid=0.
- Latency: grant edge at end of cycle N -> rsp_valid high in cycle N+2. Throughput 1 lookup/cycle.
- stall=1: req_gnt=0; pal_index, a_valid, a_id, pointer and all rsp_* hold (rsp_valid stays at its current value; the consumer treats a held pulse as a single response, so the compositor never asserts stall while rsp_valid=1).
- sync_clear=1: highest priority; req_gnt=0 that cycle; next edge a_valid=0, rsp_valid=0, pointer=0; pal_index and rsp data hold. In-flight lookups are discarded and never answered.
- Simultaneous stall and sync_clear: sync_clear wins.
- Reset mid-pipeline: all in-flight lookups are dropped; first grant after release goes to the lowest requesting index.
- No backpressure on the response; the compositor always accepts rsp_valid.

Decomposition:
- Shared package sprite_pkg: typedef rgb12_t (12-bit {r,g,b}), localparam TRANSPARENT_IDX = 8'h00, PAL_IDX_W = 8.
- Sub-module rr_arbiter (req, pointer, enable -> one-hot grant plus encoded id). It is pure combinational; the pointer register lives in the parent.
- The palette ROM stays external so one arbiter can front any sprite palette.

Test Plan:
- Single requester: req=4'b0010, index 8'h05, palette returns 12'hAB6 -> req_gnt=4'b0010 in cycle 0; rsp_valid in cycle 2 with rsp_id=1, rsp_rgb=12'hAB6, rsp_transparent=0.
- All four requesting continuously from reset -> grants 0,1,2,3,0,... one per cycle; responses in the same order, 2 cycles behind, back-to-back rsp_valid.
- Pointer wrap with NUM_REQ=3: grant to 2, then req=3'b101 -> next grant goes to 0, then 2.
- Index 8'h00 requested -> rsp_transparent=1, rsp_rgb=12'h000.
- stall asserted for 3 cycles with two lookups in flight -> no grants; pal_index and pointer frozen; after release the responses emerge with their original ids and no loss or duplication.
- sync_clear in the cycle after a grant to requester 2 -> no response for it; pointer=0; next grant with req=4'b1111 goes to 0. reset_n pulsed mid-stream -> all outputs are 0 immediately (asynchronous).
